// File: rtl/sram_like_bridge.sv
`default_nettype none
// ------------------------------------------------------------------------
// Module : sram_like_bridge
// Core sram-style port -> sram-like req/addr_ok/data_ok handshake bridge.
// Rev    : 1.0  initial release
// ------------------------------------------------------------------------
module sram_like_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int SIZE_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  // core side
  input  logic              cpu_en_i,
  input  logic [BE_W-1:0]   cpu_wen_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_hold_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              size_err_o,
  // sram-like side
  output logic              req_o,
  output logic              wr_o,
  output logic [SIZE_W-1:0] size_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              addr_ok_i,
  input  logic              data_ok_i
);

  localparam int                C_LOG2_BE   = $clog2(BE_W);
  localparam logic [SIZE_W-1:0] C_FULL_SIZE = SIZE_W'(C_LOG2_BE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              size_err_q, size_err_d;

  logic              mask_legal;
  logic [SIZE_W-1:0] mask_size;
  logic [BE_W-1:0]   pat;
  logic              wr_in;

  // A mask is legal when it is a contiguous run of 2^k bytes aligned to 2^k.
  always_comb begin
    mask_legal = 1'b0;
    mask_size  = C_FULL_SIZE;
    pat        = '0;
    for (int k = 0; k <= C_LOG2_BE; k++) begin
      for (int j = 0; j < BE_W; j += (1 << k)) begin
        for (int b = 0; b < BE_W; b++) begin
          pat[b] = (b >= j) && (b < j + (1 << k));
        end
        if (!mask_legal && (cpu_wen_i == pat)) begin
          mask_legal = 1'b1;
          mask_size  = SIZE_W'(k);
        end
      end
    end
  end

  assign wr_in = |cpu_wen_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_err_q <= size_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    size_err_d  = 1'b0;
    req_o       = 1'b0;
    wr_o        = wr_q;
    size_o      = size_q;
    addr_o      = addr_q;
    wdata_o     = wdata_q;
    cpu_stall_o = 1'b0;

    case (state_q)
      IDLE: begin
        // Request goes out in the same cycle the core asks, straight from cpu_*.
        req_o       = cpu_en_i;
        wr_o        = wr_in;
        size_o      = mask_size;
        addr_o      = cpu_addr_i;
        wdata_o     = cpu_wdata_i;
        cpu_stall_o = cpu_en_i;
        if (cpu_en_i) begin
          wr_d       = wr_in;
          size_d     = mask_size;
          addr_d     = cpu_addr_i;
          wdata_d    = cpu_wdata_i;
          size_err_d = wr_in & ~mask_legal;
          state_d    = addr_ok_i ? DATA : ADDR;
        end
      end
      ADDR: begin
        req_o       = 1'b1;
        cpu_stall_o = 1'b1;
        if (addr_ok_i) begin
          state_d = DATA;
        end
      end
      DATA: begin
        cpu_stall_o = 1'b1;
        if (data_ok_i) begin
          rdata_d = rdata_i;
          state_d = DONE;
        end
      end
      DONE: begin
        // Stall released here so the core advances exactly once per access.
        if (!cpu_hold_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rdata_o = rdata_q;
  assign size_err_o  = size_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_bridge.sv
`default_nettype none
// Directed self-checking bench for sram_like_bridge (DATA_W=32, BE_W=4).
module tb_sram_like_bridge;

  logic        clk;
  logic        rstn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        size_err;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  int errors = 0;
  int checks = 0;

  sram_like_bridge #(
    .DATA_W(32),
    .ADDR_W(32),
    .BE_W  (4),
    .SIZE_W(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_en_i   (cpu_en),
    .cpu_wen_i  (cpu_wen),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_hold_i (cpu_hold),
    .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .size_err_o (size_err),
    .req_o      (req),
    .wr_o       (wr),
    .size_o     (size),
    .addr_o     (addr),
    .wdata_o    (wdata),
    .rdata_i    (rdata),
    .addr_ok_i  (addr_ok),
    .data_ok_i  (data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic hold, input logic aok,
                       input logic dok, input logic [31:0] rd);
    @(negedge clk);
    cpu_en = en; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
    cpu_hold = hold; addr_ok = aok; data_ok = dok; rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_hold = 0; addr_ok = 0; data_ok = 0; rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (req !== 1'b0 || cpu_stall !== 1'b0 || size_err !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b stall=%b size_err=%b rdata=%h, want 0 0 0 00000000",
               req, cpu_stall, size_err, cpu_rdata);
    end
    @(negedge clk); rstn = 1'b1;
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: req=%b stall=%b, want 0 0", req, cpu_stall);
    end
  endtask

  task automatic test_read();
    int nreq = 0, nstall = 0;
    drive(1, 4'b0000, 32'h1FC0_0010, 32'h0, 0, 1, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || wr !== 1'b0 || size !== 2'd2 || addr !== 32'h1FC0_0010) begin
      errors++;
      $display("FAIL read_issue: req=%b wr=%b size=%0d addr=%h, want 1 0 2 1fc00010",
               req, wr, size, addr);
    end
    nreq += int'(req); nstall += int'(cpu_stall);
    drive(1, 4'b0000, 32'h1FC0_0010, 32'h0, 0, 0, 0, 32'h0);
    nreq += int'(req); nstall += int'(cpu_stall);
    drive(1, 4'b0000, 32'h1FC0_0010, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
    nreq += int'(req); nstall += int'(cpu_stall);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    nreq += int'(req); nstall += int'(cpu_stall);
    checks++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_data: cpu_rdata=%h, want deadbeef", cpu_rdata);
    end
    checks++;
    if (nreq != 1 || nstall != 3) begin
      errors++;
      $display("FAIL read_counts: req_cycles=%0d stall_cycles=%0d, want 1 3", nreq, nstall);
    end
  endtask

  task automatic test_write();
    int nerr = 0;
    drive(1, 4'b0100, 32'h0000_0402, 32'h00AB_0000, 0, 0, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || wr !== 1'b1 || size !== 2'd0 || addr !== 32'h0000_0402 ||
        wdata !== 32'h00AB_0000) begin
      errors++;
      $display("FAIL write_issue: req=%b wr=%b size=%0d addr=%h wdata=%h, want 1 1 0 00000402 00ab0000",
               req, wr, size, addr, wdata);
    end
    nerr += int'(size_err);
    drive(1, 4'b0100, 32'h0000_0402, 32'h00AB_0000, 0, 1, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || wr !== 1'b1 || size !== 2'd0 || addr !== 32'h0000_0402 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL write_addr: req=%b wr=%b size=%0d addr=%h stall=%b, want 1 1 0 00000402 1",
               req, wr, size, addr, cpu_stall);
    end
    nerr += int'(size_err);
    drive(1, 4'b0100, 32'h0000_0402, 32'h00AB_0000, 0, 0, 1, 32'h0);
    nerr += int'(size_err);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    nerr += int'(size_err);
    checks++;
    if (cpu_stall !== 1'b0 || req !== 1'b0 || nerr != 0) begin
      errors++;
      $display("FAIL write_done: stall=%b req=%b size_err_cycles=%0d, want 0 0 0", cpu_stall, req, nerr);
    end
  endtask

  task automatic test_addr_hold();
    int nreq = 0;
    drive(1, 4'b1111, 32'h1000_0000, 32'h1111_1111, 0, 0, 0, 32'h0);
    nreq += int'(req);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 4'b0011, 32'h2000_0000 + i, 32'h2222_0000 + i, 0, (i == 3), 0, 32'h0);
      nreq += int'(req);
      checks++;
      if (req !== 1'b1 || addr !== 32'h1000_0000 || wdata !== 32'h1111_1111 ||
          wr !== 1'b1 || size !== 2'd2) begin
        errors++;
        $display("FAIL addr_hold_%0d: req=%b addr=%h wdata=%h wr=%b size=%0d, want 1 10000000 11111111 1 2",
                 i, req, addr, wdata, wr, size);
      end
    end
    drive(1, 4'b0011, 32'h2000_0004, 32'h0, 0, 0, 0, 32'h0);
    nreq += int'(req);
    checks++;
    if (nreq != 4 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL addr_hold_count: req_cycles=%0d stall=%b, want 4 1", nreq, cpu_stall);
    end
    drive(1, 4'b0011, 32'h2000_0004, 32'h0, 0, 0, 1, 32'h0);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_hold();
    drive(1, 4'b0000, 32'h0000_0300, 32'h0, 0, 1, 0, 32'h0);
    drive(1, 4'b0000, 32'h0000_0300, 32'h0, 0, 0, 1, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0000, 32'h0000_0304, 32'h0, 1, 0, 0, 32'hFFFF_0000 + i);
      checks++;
      if (req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL hold_%0d: req=%b stall=%b rdata=%h, want 0 0 12345678",
                 i, req, cpu_stall, cpu_rdata);
      end
    end
    drive(1, 4'b0000, 32'h0000_0304, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: req=%b stall=%b, want 0 0", req, cpu_stall);
    end
    drive(1, 4'b0000, 32'h0000_0304, 32'h0, 0, 1, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || cpu_stall !== 1'b1 || addr !== 32'h0000_0304) begin
      errors++;
      $display("FAIL hold_next_req: req=%b stall=%b addr=%h, want 1 1 00000304", req, cpu_stall, addr);
    end
    drive(1, 4'b0000, 32'h0000_0304, 32'h0, 0, 0, 1, 32'h0BAD_F00D);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (cpu_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL hold_next_data: cpu_rdata=%h, want 0badf00d", cpu_rdata);
    end
  endtask

  task automatic test_size_table();
    logic [3:0] masks [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                               4'b1100, 4'b1111, 4'b0110, 4'b0000, 4'b0111};
    logic [1:0] sizes [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 10; i++) begin
      drive(0, masks[i], 32'h4000_0000 + i, 32'h0, 0, 0, 0, 32'h0);
      checks++;
      if (size !== sizes[i] || wr !== (|masks[i]) || req !== 1'b0 || size_err !== 1'b0 ||
          addr !== 32'h4000_0000 + i) begin
        errors++;
        $display("FAIL size_table_%b: size=%0d wr=%b req=%b size_err=%b addr=%h, want %0d %b 0 0 %h",
                 masks[i], size, wr, req, size_err, addr, sizes[i], |masks[i], 32'h4000_0000 + i);
      end
    end
  endtask

  task automatic test_bad_mask();
    int nerr = 0;
    drive(1, 4'b0101, 32'h0000_0010, 32'h0055_0055, 0, 1, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || wr !== 1'b1 || size !== 2'd2) begin
      errors++;
      $display("FAIL bad_mask_issue: req=%b wr=%b size=%0d, want 1 1 2", req, wr, size);
    end
    nerr += int'(size_err);
    drive(1, 4'b0101, 32'h0000_0010, 32'h0055_0055, 0, 0, 0, 32'h0);
    nerr += int'(size_err);
    drive(1, 4'b0101, 32'h0000_0010, 32'h0055_0055, 0, 0, 1, 32'h0);
    nerr += int'(size_err);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    nerr += int'(size_err);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    nerr += int'(size_err);
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL bad_mask_pulse: size_err_cycles=%0d, want 1", nerr);
    end
  endtask

  task automatic test_en_drop();
    drive(1, 4'b0000, 32'h0000_0500, 32'h0, 0, 0, 0, 32'h0);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || cpu_stall !== 1'b1 || addr !== 32'h0000_0500) begin
      errors++;
      $display("FAIL en_drop_addr: req=%b stall=%b addr=%h, want 1 1 00000500", req, cpu_stall, addr);
    end
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 32'hA5A5_0001);
    drive(1, 4'b0000, 32'h0000_0600, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL en_drop_done: req=%b stall=%b rdata=%h, want 0 0 a5a50001", req, cpu_stall, cpu_rdata);
    end
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    drive(1, 4'b0000, 32'h0000_0020, 32'h0, 0, 1, 0, 32'h0);
    drive(1, 4'b0000, 32'h0000_0020, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (cpu_stall !== 1'b1 || req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data: stall=%b req=%b, want 1 0", cpu_stall, req);
    end
    @(negedge clk);
    cpu_en = 1'b0; rstn = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: req=%b stall=%b rdata=%h, want 0 0 00000000", req, cpu_stall, cpu_rdata);
    end
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rstn = 1'b1;
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 32'hCAFE_F00D);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (cpu_rdata !== 32'h0 || req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_data: rdata=%h req=%b stall=%b, want 00000000 0 0", cpu_rdata, req, cpu_stall);
    end
    drive(1, 4'b0000, 32'h0000_0700, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (req !== 1'b1 || addr !== 32'h0000_0700) begin
      errors++;
      $display("FAIL rst_idle_req: req=%b addr=%h, want 1 00000700", req, addr);
    end
    drive(1, 4'b0000, 32'h0000_0700, 32'h0, 0, 1, 0, 32'h0);
    drive(1, 4'b0000, 32'h0000_0700, 32'h0, 0, 0, 1, 32'h7777_7777);
    drive(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    checks++;
    if (cpu_rdata !== 32'h7777_7777) begin
      errors++;
      $display("FAIL rst_recover: cpu_rdata=%h, want 77777777", cpu_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_addr_hold();
    test_hold();
    test_size_table();
    test_bad_mask();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
